tour_move_sequencer: RTL and testbench

// Sequences a solved Knight's tour into cmd_proc move commands. Sits between

---
 rtl/tour_move_sequencer_if.sv | 22 ++
 rtl/tour_move_sequencer.sv | 130 +++++++++++++
 tb/tb_tour_move_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tour_move_sequencer_if.sv
// rtl/tour_move_sequencer_if.sv - UART, cmd_proc and TourLogic signal bundle for the tour sequencer
interface tour_move_sequencer_if;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;
  logic [7:0]  move;
  logic [4:0]  mv_indx;

  modport master (
    input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp, move,
    output cmd, cmd_rdy, resp, mv_indx
  );

  modport slave (
    output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp, move,
    input  cmd, cmd_rdy, resp, mv_indx
  );
endinterface

// File: rtl/tour_move_sequencer.sv
// rtl/tour_move_sequencer.sv - replays a solved knight's tour as vertical/horizontal cmd_proc commands
module tour_move_sequencer #(
  parameter int NUM_MOVES = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_tour_i,
  output logic                 tour_err_o,
  tour_move_sequencer_if.master bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VERT   = 3'd1;
  localparam logic [2:0] HOLD_V = 3'd2;
  localparam logic [2:0] HORZ   = 3'd3;
  localparam logic [2:0] HOLD_H = 3'd4;

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  logic [2:0]  state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;
  logic        tour_err_q, tour_err_d;

  logic        move_legal;
  logic        dx_pos, dy_pos;
  logic [3:0]  dx_mag, dy_mag;
  logic [15:0] vert_cmd, horz_cmd;
  logic        last_move;

  always_comb begin
    move_legal = 1'b1;
    dx_pos     = 1'b1;
    dy_pos     = 1'b1;
    dx_mag     = 4'd0;
    dy_mag     = 4'd0;
    case (bus.move)
      8'h01: begin dx_mag = 4'd1; dy_mag = 4'd2; end
      8'h02: begin dx_pos = 1'b0; dx_mag = 4'd1; dy_mag = 4'd2; end
      8'h04: begin dx_pos = 1'b0; dx_mag = 4'd2; dy_mag = 4'd1; end
      8'h08: begin dx_pos = 1'b0; dy_pos = 1'b0; dx_mag = 4'd2; dy_mag = 4'd1; end
      8'h10: begin dx_pos = 1'b0; dy_pos = 1'b0; dx_mag = 4'd1; dy_mag = 4'd2; end
      8'h20: begin dy_pos = 1'b0; dx_mag = 4'd1; dy_mag = 4'd2; end
      8'h40: begin dy_pos = 1'b0; dx_mag = 4'd2; dy_mag = 4'd1; end
      8'h80: begin dx_mag = 4'd2; dy_mag = 4'd1; end
      default: move_legal = 1'b0;
    endcase
  end

  assign vert_cmd  = {4'h2, (dy_pos ? 8'h00 : 8'h7F), dy_mag};
  assign horz_cmd  = {4'h3, (dx_pos ? 8'hBF : 8'h3F), dx_mag};
  assign last_move = (mv_indx_q == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    mv_indx_d  = mv_indx_q;
    tour_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_tour_i) begin
          mv_indx_d = 5'd0;
          state_d   = VERT;
        end
      end
      VERT: begin
        if (!move_legal) begin
          tour_err_d = 1'b1;
          state_d    = IDLE;
        end else if (bus.clr_cmd_rdy) begin
          state_d = HOLD_V;
        end
      end
      HOLD_V: if (bus.send_resp) state_d = HORZ;
      HORZ:   if (bus.clr_cmd_rdy) state_d = HOLD_H;
      HOLD_H: begin
        if (bus.send_resp) begin
          if (last_move) begin
            state_d = IDLE;
          end else begin
            mv_indx_d = mv_indx_q + 5'd1;
            state_d   = VERT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mv_indx_q  <= 5'd0;
      tour_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mv_indx_q  <= mv_indx_d;
      tour_err_q <= tour_err_d;
    end
  end

  // An illegal move is caught in VERT; cmd_rdy is gated so cmd_proc never sees it.
  always_comb begin
    bus.cmd     = bus.cmd_UART;
    bus.cmd_rdy = 1'b0;
    bus.resp    = 8'h5A;
    case (state_q)
      IDLE: begin
        bus.cmd_rdy = bus.cmd_rdy_UART;
        bus.resp    = 8'hA5;
      end
      VERT: begin
        bus.cmd     = vert_cmd;
        bus.cmd_rdy = move_legal;
      end
      HOLD_V: bus.cmd = vert_cmd;
      HORZ: begin
        bus.cmd     = horz_cmd;
        bus.cmd_rdy = 1'b1;
      end
      HOLD_H: begin
        bus.cmd = horz_cmd;
        if (last_move) bus.resp = 8'hA5;
      end
      default: bus.cmd = 16'h0000;
    endcase
  end

  assign bus.mv_indx = mv_indx_q;
  assign tour_err_o  = tour_err_q;

endmodule

// File: tb/tb_tour_move_sequencer.sv
// tb/tb_tour_move_sequencer.sv - randomized self-checking bench for tour_move_sequencer
`timescale 1ns/1ps
module tb_tour_move_sequencer;
  localparam int NUM_MOVES = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_tour = 1'b0;
  logic tour_err;
  logic [7:0] mem [0:31];
  int errors = 0;
  int checks = 0;
  int handshakes = 0;

  tour_move_sequencer_if bus();

  tour_move_sequencer #(.NUM_MOVES(NUM_MOVES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour_i (start_tour),
    .tour_err_o   (tour_err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  assign bus.move = mem[bus.mv_indx];

  // Reference: knight displacement per one-hot bit, turned into command words.
  function automatic void model_cmds(input logic [7:0] mv, output logic [15:0] v, output logic [15:0] h);
    int dx_tab [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int dy_tab [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
    int dx = 0;
    int dy = 0;
    logic [7:0] one;
    for (int b = 0; b < 8; b++) begin
      one = 8'd1 << b;
      if (mv == one) begin
        dx = dx_tab[b];
        dy = dy_tab[b];
      end
    end
    v = {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
    h = {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
  endfunction

  function automatic logic [7:0] rand_onehot();
    logic [7:0] one;
    one = 8'd1;
    return one << $urandom_range(0, 7);
  endfunction

  task automatic fill_random_tour();
    for (int i = 0; i < 32; i++) mem[i] = rand_onehot();
  endtask

  task automatic pulse_start();
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
  endtask

  // Plays cmd_proc for one command; entered and left on a negedge.
  task automatic handshake(input logic [15:0] exp_cmd, input logic [7:0] exp_resp,
                           input bit is_vert, input string tag);
    checks++;
    if (bus.cmd_rdy !== 1'b1 || bus.cmd !== exp_cmd) begin
      errors++;
      $display("FAIL %s issue: got rdy=%b cmd=%h, want rdy=1 cmd=%h", tag, bus.cmd_rdy, bus.cmd, exp_cmd);
    end
    if (bus.cmd_rdy === 1'b1) handshakes++;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.clr_cmd_rdy = 1'b1;
    bus.send_resp   = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      bus.clr_cmd_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.clr_cmd_rdy = 1'b0;
    checks++;
    if (bus.cmd_rdy !== 1'b0 || (is_vert && bus.cmd !== exp_cmd)) begin
      errors++;
      $display("FAIL %s hold: got rdy=%b cmd=%h, want rdy=0 cmd=%h", tag, bus.cmd_rdy, bus.cmd, exp_cmd);
    end
    bus.send_resp = 1'b1;
    checks++;
    if (bus.resp !== exp_resp) begin
      errors++;
      $display("FAIL %s resp: got %h, want %h", tag, bus.resp, exp_resp);
    end
    @(negedge clk);
    bus.send_resp = 1'b0;
  endtask

  task automatic run_move(input int idx, input bit last);
    logic [15:0] v, h;
    model_cmds(mem[idx], v, h);
    checks++;
    if (bus.mv_indx !== 5'(idx)) begin
      errors++;
      $display("FAIL mv_indx move %0d: got %0d, want %0d", idx, bus.mv_indx, idx);
    end
    handshake(v, 8'h5A, 1'b1, "vert");
    handshake(h, last ? 8'hA5 : 8'h5A, 1'b0, "horz");
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.cmd_UART = 16'h1234;
    bus.cmd_rdy_UART = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mv_indx !== 5'd0 || tour_err !== 1'b0 || bus.resp !== 8'hA5 ||
        bus.cmd_rdy !== 1'b0 || bus.cmd !== 16'h1234) begin
      errors++;
      $display("FAIL reset: got idx=%0d err=%b resp=%h rdy=%b cmd=%h, want 0 0 a5 0 1234",
               bus.mv_indx, tour_err, bus.resp, bus.cmd_rdy, bus.cmd);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    logic [15:0] c;
    logic r;
    for (int i = 0; i < 5; i++) begin
      c = (i == 0) ? 16'h2003 : 16'($urandom);
      r = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.cmd_UART = c;
      bus.cmd_rdy_UART = r;
      @(negedge clk);
      checks++;
      if (bus.cmd !== c || bus.cmd_rdy !== r || bus.resp !== 8'hA5) begin
        errors++;
        $display("FAIL passthrough %0d: got cmd=%h rdy=%b resp=%h, want %h %b a5",
                 i, bus.cmd, bus.cmd_rdy, bus.resp, c, r);
      end
    end
    bus.cmd_rdy_UART = 1'b0;
  endtask

  task automatic test_single_moves();
    fill_random_tour();
    mem[0] = 8'h01;
    mem[1] = 8'h08;
    bus.cmd_UART = 16'hFFFF;
    bus.cmd_rdy_UART = 1'b1;
    pulse_start();
    handshake(16'h2002, 8'h5A, 1'b1, "m0 vert");
    handshake(16'h3BF1, 8'h5A, 1'b0, "m0 horz");
    checks++;
    if (bus.mv_indx !== 5'd1) begin
      errors++;
      $display("FAIL advance: got mv_indx=%0d, want 1", bus.mv_indx);
    end
    handshake(16'h27F1, 8'h5A, 1'b1, "m1 vert");
    handshake(16'h33F2, 8'h5A, 1'b0, "m1 horz");
    apply_reset();
    bus.cmd_rdy_UART = 1'b0;
  endtask

  task automatic test_full_tour();
    logic [15:0] c;
    fill_random_tour();
    handshakes = 0;
    c = 16'($urandom);
    bus.cmd_UART = c;
    bus.cmd_rdy_UART = 1'b1;
    pulse_start();
    for (int i = 0; i < NUM_MOVES; i++) run_move(i, i == NUM_MOVES - 1);
    checks++;
    if (handshakes != 2 * NUM_MOVES) begin
      errors++;
      $display("FAIL tour handshakes: got %0d, want %0d", handshakes, 2 * NUM_MOVES);
    end
    checks++;
    if (bus.mv_indx !== 5'(NUM_MOVES - 1) || bus.cmd !== c || bus.cmd_rdy !== 1'b1 || bus.resp !== 8'hA5) begin
      errors++;
      $display("FAIL tour end: got idx=%0d cmd=%h rdy=%b resp=%h, want %0d %h 1 a5",
               bus.mv_indx, bus.cmd, bus.cmd_rdy, bus.resp, NUM_MOVES - 1, c);
    end
    bus.cmd_rdy_UART = 1'b0;
  endtask

  task automatic watch_abort(input int exp_idx, input string tag);
    int err_cnt = 0;
    int rdy_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (tour_err === 1'b1) err_cnt++;
      if (bus.cmd_rdy !== 1'b0) rdy_cnt++;
      @(negedge clk);
    end
    checks++;
    if (err_cnt != 1 || rdy_cnt != 0 || bus.mv_indx !== 5'(exp_idx)) begin
      errors++;
      $display("FAIL %s: got err_pulses=%0d rdy_cycles=%0d idx=%0d, want 1 0 %0d",
               tag, err_cnt, rdy_cnt, bus.mv_indx, exp_idx);
    end
  endtask

  task automatic test_illegal();
    fill_random_tour();
    mem[5] = 8'h03;
    bus.cmd_rdy_UART = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) run_move(i, 1'b0);
    watch_abort(5, "illegal idx5");
    mem[0] = 8'h00;
    pulse_start();
    watch_abort(0, "illegal idx0");
    mem[0] = rand_onehot();
    pulse_start();
    run_move(0, 1'b0);
    apply_reset();
  endtask

  task automatic test_reset_mid_tour();
    logic [15:0] v, h, c;
    fill_random_tour();
    bus.cmd_rdy_UART = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) run_move(i, 1'b0);
    model_cmds(mem[10], v, h);
    handshake(v, 8'h5A, 1'b1, "m10 vert");
    pulse_start();
    checks++;
    if (bus.mv_indx !== 5'd10 || bus.cmd_rdy !== 1'b1 || bus.cmd !== h) begin
      errors++;
      $display("FAIL start in HORZ: got idx=%0d rdy=%b cmd=%h, want 10 1 %h", bus.mv_indx, bus.cmd_rdy, bus.cmd, h);
    end
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    c = 16'($urandom);
    bus.cmd_UART = c;
    bus.cmd_rdy_UART = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mv_indx !== 5'd0 || bus.cmd_rdy !== 1'b1 || bus.cmd !== c || bus.resp !== 8'hA5) begin
      errors++;
      $display("FAIL reset in HOLD_H: got idx=%0d rdy=%b cmd=%h resp=%h, want 0 1 %h a5",
               bus.mv_indx, bus.cmd_rdy, bus.cmd, bus.resp, c);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.cmd_rdy_UART = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    bus.cmd_UART = 16'h0000;
    bus.cmd_rdy_UART = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    test_reset();
    test_passthrough();
    test_single_moves();
    test_full_tour();
    test_illegal();
    test_reset_mid_tour();
    test_full_tour();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
